class_decision: RTL and testbench
=================================

Name: class_decision

Overview:
- Sits directly downstream of the final softmax dense layer and consumes its per-class probability vector once per audio frame.
- Serially scans the vector for the argmax, then applies a confidence threshold and a consecutive-frame stability filter.
- Emits one recognised-word event per stable detection through a valid/ready handshake to the display/control logic.

Parameters:
- NUM_CLASSES, OUT_SIZE_4 (4 in bench), number of class probabilities per frame.
- PROB_W, 16, probability word width (unsigned).
- CONF_THRESH, 16'd30000, minimum winning probability for a frame to count as a detection.
- STABLE_FRAMES, 3, consecutive identical detections required before reporting (>=1).
- CLS_W, $clog2(NUM_CLASSES), class index width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- probabilities  in  PROB_W x NUM_CLASSES (unpacked array)  probability vector from the final layer.
- in_valid  in  1  vector valid.
- in_ready  out  1  block can accept a vector.
- clear  in  1  synchronous flush of the stability history.
- frame_done  out  1  one-cycle pulse when a frame decision completes.
- frame_class  out  CLS_W  raw argmax of the last frame.
- frame_prob  out  PROB_W  winning probability of the last frame.
- out_valid  out  1  stable detection available.
- out_class  out  CLS_W  reported class.
- out_conf  out  PROB_W  probability of the reporting frame.
- out_ready  in  1  consumer accepts the detection.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; frame_done=0; frame_class=0; frame_prob=0; out_class=0; out_conf=0; stable_cnt=0; last_cls=0; last_hit=0; reported=0. Reset mid-scan or mid-output abandons the frame with no output.
- FSM IDLE:
  - in_ready=1.
  - in_valid=1 registers the whole vector, clears max=0/idx=0, goes to SCAN. in_ready drops the next cycle.
- FSM SCAN:
  - Examines element i on cycle i, i=0..NUM_CLASSES-1.
  - Update rule: max/idx update only when p[i] > max (strict compare). Ties therefore keep the lowest index; an all-zero vector yields idx 0, prob 0.
  - After the last element, goes to DECIDE.
- FSM DECIDE, one cycle:
  - frame_class/frame_prob load and frame_done pulses.
  - hit = (max >= CONF_THRESH).
  - If hit and last_hit and idx==last_cls: stable_cnt += 1, saturating at STABLE_FRAMES. Otherwise, if hit: stable_cnt=1, reported=0. If not hit: stable_cnt=0, reported=0.
  - last_cls=idx, last_hit=hit.
  - If hit and stable_cnt (updated value) == STABLE_FRAMES and reported==0: load out_class/out_conf, set out_valid, reported=1, go to OUTPUT. Else go to IDLE.
- FSM OUTPUT:
  - out_valid held with stable data until out_ready=1, then out_valid=0 the next cycle and state goes to IDLE.
  - in_ready=0 throughout, so frames backpressure and are never dropped.
- Latency: vector accepted at cycle 0, frame_done at cycle NUM_CLASSES+1, out_valid earliest at cycle NUM_CLASSES+2. Throughput without backpressure: one frame per NUM_CLASSES+2 cycles.
- One report per run: a continuing stable run never re-reports. A new report needs a break (other class or sub-threshold frame) followed by STABLE_FRAMES matching frames.
- clear=1 sets stable_cnt=0, last_hit=0, reported=0 on the next edge in any state.
  - In OUTPUT, a pending out_valid is unaffected.
  - clear and a DECIDE update in the same cycle: clear wins.
- Probabilities are compared unsigned; no arithmetic beyond compare and counter increment. stable_cnt width is $clog2(STABLE_FRAMES+1).

Decomposition:
- nn_parameters package gains CONF_THRESH, STABLE_FRAMES, PROB_W, the typedef prob_t = logic [PROB_W-1:0], and the decision FSM state enum.
- Optional sub-module argmax_scan: the serial max/index scanner with start/done handshake. The debounce and output logic stay in class_decision.

Test Plan:
- Vector {1000,40000,20000,500} three times, out_ready=1 → frame_done each frame with frame_class=1, frame_prob=40000; out_valid only after the third frame, out_class=1, out_conf=40000, at cycle 6 after the third accept.
- Same vector five times → exactly one out_valid pulse. Then {40000,0,0,0} three times → second report, class 0.
- Class 2 for frames 1-2, frame 3 max=29999, frames 4-6 class 2 at 35000 → no report until frame 6.
- Tie {30000,30000,0,0} → frame_class=0. All-zero vector → frame_class=0, frame_prob=0, no hit.
- Hold out_ready=0 for 20 cycles during OUTPUT while in_valid=1 → in_ready=0 and out data stable; vector accepted the cycle after the out_ready handshake.
- rst_n pulsed low mid-SCAN, and clear asserted between frames 2 and 3 of a run → no out_valid and all outputs at reset values; run restarts from count 1.

Source files
------------

// File: rtl/class_decision_pkg.sv
// Shared constants, types and FSM encoding for the softmax class-decision stage.
// Imported by the argmax scanner and the class_decision top.
package class_decision_pkg;

  localparam int OUT_SIZE_4    = 4;
  localparam int PROB_W        = 16;
  localparam int STABLE_FRAMES = 3;
  localparam int STABLE_W      = $clog2(STABLE_FRAMES + 1);

  typedef logic [PROB_W-1:0] prob_t;

  localparam prob_t CONF_THRESH = 16'd30000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DECIDE,
    ST_OUTPUT
  } dec_state_t;

endpackage

// File: rtl/argmax_scan.sv
// Serial argmax over a registered probability vector, one element per cycle.
// done pulses on the last element with the final index and probability on idx/prob.
module argmax_scan
  import class_decision_pkg::*;
#(
  parameter int NUM_CLASSES = OUT_SIZE_4,
  parameter int CLS_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  prob_t            vec [NUM_CLASSES],
  output logic             done,
  output logic [CLS_W-1:0] idx,
  output prob_t            prob
);

  localparam logic [CLS_W-1:0] LAST_POS = CLS_W'(NUM_CLASSES - 1);

  logic             busy;
  logic [CLS_W-1:0] pos;
  logic [CLS_W-1:0] idx_q;
  prob_t            max_q;
  prob_t            cand;
  logic             take;

  // Strict compare keeps the lowest index on ties.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    cand = vec[pos];
    take = busy && (cand > max_q);
    done = busy && (pos == LAST_POS);
    idx  = take ? pos  : idx_q;
    prob = take ? cand : max_q;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      pos   <= '0;
      idx_q <= '0;
      max_q <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      pos   <= '0;
      idx_q <= '0;
      max_q <= '0;
    end else if (busy) begin
      idx_q <= idx;
      max_q <= prob;
      pos   <= pos + CLS_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/class_decision.sv
// Argmax, confidence threshold and consecutive-frame debounce on the softmax output;
// reports one recognised-word event per stable run over a valid/ready handshake.
module class_decision
  import class_decision_pkg::*;
#(
  parameter int NUM_CLASSES = OUT_SIZE_4,
  parameter int CLS_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  prob_t            probabilities [NUM_CLASSES],
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic             frame_done,
  output logic [CLS_W-1:0] frame_class,
  output prob_t            frame_prob,
  output logic             out_valid,
  output logic [CLS_W-1:0] out_class,
  output prob_t            out_conf,
  input  logic             out_ready
);

  localparam logic [STABLE_W-1:0] CNT_FULL = STABLE_W'(STABLE_FRAMES);

  dec_state_t          state_q, state_d;
  prob_t               vec_q [NUM_CLASSES];
  logic                scan_start, scan_done;
  logic [CLS_W-1:0]    scan_idx;
  prob_t               scan_prob;

  logic [STABLE_W-1:0] stable_cnt, cnt_nxt;
  logic [CLS_W-1:0]    last_cls;
  logic                last_hit, reported;
  logic                hit, same_run, rep_nxt, report_go;

  assign in_ready   = (state_q == ST_IDLE);
  assign frame_done = (state_q == ST_DECIDE);
  assign scan_start = in_ready && in_valid;

  // NOTE: the captured vector is pure data qualified by the FSM, so it carries no reset.
  always_ff @(posedge clk) begin
    if (scan_start) vec_q <= probabilities;
  end

  argmax_scan #(
    .NUM_CLASSES (NUM_CLASSES),
    .CLS_W       (CLS_W)
  ) u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .start (scan_start),
    .vec   (vec_q),
    .done  (scan_done),
    .idx   (scan_idx),
    .prob  (scan_prob)
  );

  // Debounce: a run continues only on a hit of the same class as the previous hit frame.
  always_comb begin
    hit      = (frame_prob >= CONF_THRESH);
    same_run = hit && last_hit && (frame_class == last_cls);
    cnt_nxt  = '0;
    rep_nxt  = 1'b0;
    if (same_run) begin
      cnt_nxt = (stable_cnt == CNT_FULL) ? stable_cnt : stable_cnt + STABLE_W'(1);
      rep_nxt = reported;
    end else if (hit) begin
      cnt_nxt = STABLE_W'(1);
    end
    report_go = hit && (cnt_nxt == CNT_FULL) && !rep_nxt && !clear;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (in_valid)  state_d = ST_SCAN;
      ST_SCAN:   if (scan_done) state_d = ST_DECIDE;
      ST_DECIDE: state_d = report_go ? ST_OUTPUT : ST_IDLE;
      ST_OUTPUT: if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_class <= '0;
      frame_prob  <= '0;
      out_valid   <= 1'b0;
      out_class   <= '0;
      out_conf    <= '0;
    end else begin
      if (scan_done) begin
        frame_class <= scan_idx;
        frame_prob  <= scan_prob;
      end
      if (state_q == ST_DECIDE && report_go) begin
        out_valid <= 1'b1;
        out_class <= frame_class;
        out_conf  <= frame_prob;
      end else if (state_q == ST_OUTPUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // clear flushes the run history in any state and overrides a same-cycle decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      last_cls   <= '0;
      last_hit   <= 1'b0;
      reported   <= 1'b0;
    end else begin
      if (state_q == ST_DECIDE) last_cls <= frame_class;
      if (clear) begin
        stable_cnt <= '0;
        last_hit   <= 1'b0;
        reported   <= 1'b0;
      end else if (state_q == ST_DECIDE) begin
        stable_cnt <= cnt_nxt;
        last_hit   <= hit;
        reported   <= rep_nxt | report_go;
      end
    end
  end

endmodule

// File: tb/tb_class_decision.sv
// Self-checking bench for class_decision: directed scenarios plus randomized frames
// scored against a run-length model of the detection history.
module tb_class_decision;
  import class_decision_pkg::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  prob_t      probabilities [N];
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       clear = 1'b0;
  logic       frame_done;
  logic [1:0] frame_class;
  prob_t      frame_prob;
  logic       out_valid;
  logic [1:0] out_class;
  prob_t      out_conf;
  logic       out_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  // Detection history since the last reset/clear: hit flag and winning class per frame.
  bit m_hit[$];
  int m_cls[$];

  // Observations of the most recent run_frame.
  bit         r_got;
  int         r_done_cyc, r_out_cyc, r_out_len;
  logic [1:0] r_fcls, r_ocls;
  prob_t      r_fprob, r_oconf;

  class_decision #(.NUM_CLASSES(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .probabilities (probabilities),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .clear         (clear),
    .frame_done    (frame_done),
    .frame_class   (frame_class),
    .frame_prob    (frame_prob),
    .out_valid     (out_valid),
    .out_class     (out_class),
    .out_conf      (out_conf),
    .out_ready     (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_clear();
    m_hit.delete();
    m_cls.delete();
  endfunction

  // A frame reports exactly when it completes a run of STABLE_FRAMES consecutive
  // above-threshold frames of one class.
  function automatic bit model_frame(input prob_t v[N], output int cls, output prob_t mx);
    int run;
    bit h;
    mx = '0;
    for (int i = 0; i < N; i++) if (v[i] > mx) mx = v[i];
    cls = 0;
    for (int i = N - 1; i >= 0; i--) if (v[i] == mx) cls = i;
    h = (mx >= CONF_THRESH);
    m_hit.push_back(h);
    m_cls.push_back(cls);
    run = 0;
    for (int k = m_hit.size() - 1; k >= 0; k--) begin
      if (!m_hit[k] || m_cls[k] != cls) break;
      run++;
    end
    return h && (run == STABLE_FRAMES);
  endfunction

  // Sends one frame with out_ready=1 and scores it against the model.
  task automatic run_frame(input prob_t v[N], input string tag);
    bit    exp_rep;
    int    exp_cls, waited, done_cnt;
    prob_t exp_mx;
    exp_rep = model_frame(v, exp_cls, exp_mx);
    @(negedge clk);
    probabilities = v;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept: in_ready=%b after %0d cycles, required 1", tag, in_ready, waited);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    r_got = 1'b0; r_out_cyc = -1; r_done_cyc = -1; r_out_len = 0; done_cnt = 0;
    for (int k = 1; k <= N + 4; k++) begin
      if (k > 1) @(negedge clk);
      if (frame_done === 1'b1) begin
        done_cnt++;
        r_done_cyc = k; r_fcls = frame_class; r_fprob = frame_prob;
      end
      if (out_valid === 1'b1) begin
        if (!r_got) begin
          r_got = 1'b1; r_out_cyc = k; r_ocls = out_class; r_oconf = out_conf;
        end
        r_out_len++;
      end
    end
    n_tests++;
    if (done_cnt != 1 || r_done_cyc != N + 1) begin
      n_fail++;
      $display("FAIL %s frame_done: %0d pulses at cycle %0d, required 1 at cycle %0d",
               tag, done_cnt, r_done_cyc, N + 1);
    end
    n_tests++;
    if (r_fcls !== 2'(exp_cls) || r_fprob !== exp_mx) begin
      n_fail++;
      $display("FAIL %s frame result: class=%0d prob=%0d, required class=%0d prob=%0d",
               tag, r_fcls, r_fprob, exp_cls, exp_mx);
    end
    n_tests++;
    if (r_got !== exp_rep) begin
      n_fail++;
      $display("FAIL %s report: out_valid seen=%0b, required %0b", tag, r_got, exp_rep);
    end
    if (exp_rep && r_got) begin
      n_tests++;
      if (r_out_cyc != N + 2 || r_out_len != 1 || r_ocls !== 2'(exp_cls) || r_oconf !== exp_mx) begin
        n_fail++;
        $display("FAIL %s out: cycle=%0d len=%0d class=%0d conf=%0d, required cycle=%0d len=1 class=%0d conf=%0d",
                 tag, r_out_cyc, r_out_len, r_ocls, r_oconf, N + 2, exp_cls, exp_mx);
      end
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid, frame_done, frame_class, frame_prob, out_class, out_conf} !==
        {1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 2'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b frame_done=%b fc=%0d fp=%0d oc=%0d conf=%0d, required 1 0 0 0 0 0 0",
               in_ready, out_valid, frame_done, frame_class, frame_prob, out_class, out_conf);
    end
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_basic();
    prob_t v[N];
    v = '{16'd1000, 16'd40000, 16'd20000, 16'd500};
    for (int f = 0; f < 3; f++) begin
      run_frame(v, "basic");
      n_tests++;
      if (r_got !== (f == 2) || r_fcls !== 2'd1 || r_fprob !== 16'd40000) begin
        n_fail++;
        $display("FAIL basic frame %0d: got=%0b class=%0d prob=%0d, required got=%0b class=1 prob=40000",
                 f, r_got, r_fcls, r_fprob, f == 2);
      end
    end
    n_tests++;
    if (r_out_cyc != 6 || r_ocls !== 2'd1 || r_oconf !== 16'd40000) begin
      n_fail++;
      $display("FAIL basic out: cycle=%0d class=%0d conf=%0d, required 6 1 40000", r_out_cyc, r_ocls, r_oconf);
    end
  endtask

  task automatic test_one_report();
    prob_t v[N], w[N];
    int    reports;
    v = '{16'd1000, 16'd40000, 16'd20000, 16'd500};
    w = '{16'd40000, 16'd0, 16'd0, 16'd0};
    pulse_clear();
    reports = 0;
    for (int f = 0; f < 5; f++) begin
      run_frame(v, "one_report");
      if (r_got) reports++;
    end
    for (int f = 0; f < 3; f++) begin
      run_frame(w, "second_report");
      if (r_got) reports++;
    end
    n_tests++;
    if (reports != 2 || r_ocls !== 2'd0) begin
      n_fail++;
      $display("FAIL one_report: reports=%0d last class=%0d, required 2 and 0", reports, r_ocls);
    end
  endtask

  task automatic test_threshold();
    prob_t v[N], low[N];
    int    first_rep;
    v   = '{16'd0, 16'd0, 16'd35000, 16'd100};
    low = '{16'd0, 16'd0, 16'd29999, 16'd0};
    first_rep = 0;
    for (int f = 1; f <= 6; f++) begin
      run_frame((f == 3) ? low : v, "threshold");
      if (r_got && first_rep == 0) first_rep = f;
    end
    n_tests++;
    if (first_rep != 6) begin
      n_fail++;
      $display("FAIL threshold: first report at frame %0d, required 6", first_rep);
    end
  endtask

  task automatic test_tie_zero();
    prob_t t[N], z[N];
    t = '{16'd30000, 16'd30000, 16'd0, 16'd0};
    z = '{16'd0, 16'd0, 16'd0, 16'd0};
    run_frame(t, "tie");
    n_tests++;
    if (r_fcls !== 2'd0 || r_fprob !== 16'd30000) begin
      n_fail++;
      $display("FAIL tie: class=%0d prob=%0d, required 0 30000", r_fcls, r_fprob);
    end
    run_frame(z, "zero");
    n_tests++;
    if (r_fcls !== 2'd0 || r_fprob !== 16'd0 || r_got !== 1'b0) begin
      n_fail++;
      $display("FAIL zero: class=%0d prob=%0d got=%0b, required 0 0 0", r_fcls, r_fprob, r_got);
    end
  endtask

  task automatic test_backpressure();
    prob_t va[N], vb[N];
    int    exp_cls, waited, bad;
    prob_t exp_mx, held_conf;
    logic [1:0] held_cls;
    bit    exp_rep;
    va = '{16'd0, 16'd50000, 16'd0, 16'd0};
    vb = '{16'd0, 16'd0, 16'd0, 16'd45000};
    out_ready = 1'b0;
    run_frame(va, "bp_prime");
    run_frame(va, "bp_prime");
    exp_rep = model_frame(va, exp_cls, exp_mx);
    @(negedge clk);
    probabilities = va;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    probabilities = vb;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    held_cls = out_class;
    held_conf = out_conf;
    n_tests++;
    if (out_valid !== exp_rep || held_cls !== 2'(exp_cls) || held_conf !== exp_mx) begin
      n_fail++;
      $display("FAIL bp report: out_valid=%b class=%0d conf=%0d, required %0b %0d %0d",
               out_valid, held_cls, held_conf, exp_rep, exp_cls, exp_mx);
    end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_class !== held_cls || out_conf !== held_conf) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp hold: %0d unstable cycles of 20, required 0", bad);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    exp_rep = model_frame(vb, exp_cls, exp_mx);
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp accept: in_ready=%b, required 0 after accept", in_ready);
    end
    waited = 0;
    while (frame_done !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (frame_done !== 1'b1 || frame_class !== 2'(exp_cls) || frame_prob !== exp_mx) begin
      n_fail++;
      $display("FAIL bp held frame: done=%b class=%0d prob=%0d, required 1 %0d %0d",
               frame_done, frame_class, frame_prob, exp_cls, exp_mx);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midscan();
    prob_t v[N];
    int    first_rep;
    v = '{16'd0, 16'd0, 16'd60000, 16'd0};
    run_frame(v, "midscan_prime");
    run_frame(v, "midscan_prime");
    @(negedge clk);
    probabilities = v;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, out_valid, frame_done, frame_class, frame_prob, out_class, out_conf} !==
        {1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 2'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL midscan reset: in_ready=%b out_valid=%b frame_done=%b fc=%0d fp=%0d oc=%0d conf=%0d, required 1 0 0 0 0 0 0",
               in_ready, out_valid, frame_done, frame_class, frame_prob, out_class, out_conf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    first_rep = 0;
    for (int f = 1; f <= 3; f++) begin
      run_frame(v, "after_reset");
      if (r_got && first_rep == 0) first_rep = f;
    end
    n_tests++;
    if (first_rep != 3) begin
      n_fail++;
      $display("FAIL after_reset: first report at frame %0d, required 3", first_rep);
    end
  endtask

  task automatic test_clear();
    prob_t v[N];
    int    first_rep;
    v = '{16'd33000, 16'd0, 16'd0, 16'd0};
    first_rep = 0;
    for (int f = 1; f <= 5; f++) begin
      if (f == 3) pulse_clear();
      run_frame(v, "clear");
      if (r_got && first_rep == 0) first_rep = f;
    end
    n_tests++;
    if (first_rep != 5) begin
      n_fail++;
      $display("FAIL clear: first report at frame %0d, required 5", first_rep);
    end
  endtask

  task automatic test_random();
    prob_t v[N];
    int    cls;
    cls = 0;
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 11) == 0) pulse_clear();
      if ($urandom_range(0, 9) < 3) cls = $urandom_range(0, N - 1);
      for (int i = 0; i < N; i++) v[i] = 16'($urandom_range(0, 20000));
      if ($urandom_range(0, 9) < 8) v[cls] = 16'($urandom_range(30000, 65535));
      else                          v[cls] = 16'($urandom_range(0, 40000));
      run_frame(v, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) probabilities[i] = '0;
    test_reset();
    test_basic();
    test_one_report();
    test_threshold();
    test_tie_zero();
    test_backpressure();
    test_reset_midscan();
    test_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
